// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, halt opcode field and PC step.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int          HLT_MSB = 15;
    localparam int          HLT_LSB = 12;
    localparam logic [15:0] PC_INCR = 16'd2;

    function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] opcode);
        return instr[HLT_MSB:HLT_LSB] == opcode;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with load enable.
// Latency: one cycle from pc_d/en to pc_q; no backpressure.
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] pc_d,
    output logic [15:0] pc_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one request per FETCH/WAIT pair, delivery into IF/ID.
// Latency: 2 cycles minimum per instruction; StallIn parks the word in a hold buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallIn,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    input  logic        MemReady,
    input  logic [15:0] MemData,
    output logic        MemEnable,
    output logic [15:0] MemAddr,
    output logic [15:0] InstructionOut,
    output logic [15:0] PCOut,
    output logic        HltOut,
    output logic        NoopOut,
    output logic        IFIDWriteEnable,
    output logic        Halted
);

    state_t      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic        discard_q, discard_d;
    logic [15:0] pc_q, pc_d, pc_plus;
    logic        pc_en;
    logic        deliver;
    logic [15:0] instr_sel;
    logic        instr_halt;

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk  (clk),
        .rst  (rst),
        .en   (pc_en),
        .pc_d (pc_d),
        .pc_q (pc_q)
    );

    assign pc_plus    = pc_q + PC_INCR;
    assign instr_sel  = (state_q == ST_HOLD) ? hold_q : MemData;
    assign instr_halt = is_halt(instr_sel, HLT_OPCODE);
    assign deliver    = !StallIn &&
                        ((state_q == ST_WAIT && MemReady && !discard_q) || state_q == ST_HOLD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            hold_q    <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        discard_d = discard_q;
        pc_d      = pc_plus;
        pc_en     = 1'b0;
        if (BranchTaken) begin
            pc_d      = BranchTarget;
            pc_en     = 1'b1;
            hold_d    = '0;
            discard_d = 1'b0;
            state_d   = ST_FETCH;
            // A response still in flight must drain before the new request goes out.
            if (state_q == ST_WAIT && !MemReady) begin
                state_d   = ST_WAIT;
                discard_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (MemReady) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = ST_FETCH;
                        end else if (StallIn) begin
                            hold_d  = MemData;
                            state_d = ST_HOLD;
                        end else if (instr_halt) begin
                            state_d = ST_HALTED;
                        end else begin
                            pc_en   = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!StallIn) begin
                        if (instr_halt) begin
                            state_d = ST_HALTED;
                        end else begin
                            pc_en   = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        MemEnable       = 1'b0;
        MemAddr         = '0;
        InstructionOut  = '0;
        PCOut           = '0;
        HltOut          = 1'b0;
        NoopOut         = 1'b0;
        IFIDWriteEnable = 1'b0;
        Halted          = 1'b0;
        if (!rst) begin
            if (BranchTaken) begin
                NoopOut         = 1'b1;
                IFIDWriteEnable = 1'b1;
            end else if (deliver) begin
                IFIDWriteEnable = 1'b1;
                InstructionOut  = instr_sel;
                PCOut           = pc_plus;
                HltOut          = instr_halt;
            end
            unique case (state_q)
                ST_FETCH:  MemEnable = !BranchTaken;
                ST_WAIT:   MemEnable = !discard_q;
                ST_HOLD:   if (!BranchTaken) InstructionOut = hold_q;
                ST_HALTED: Halted = !BranchTaken;
                default:   MemEnable = 1'b0;
            endcase
            if (MemEnable) MemAddr = pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector table plus IF/ID write scoreboard.
module tb_fetch_stage;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        StallIn = 1'b0, BranchTaken = 1'b0, MemReady = 1'b0;
    logic [15:0] BranchTarget = '0, MemData = '0;
    logic        MemEnable, HltOut, NoopOut, IFIDWriteEnable, Halted;
    logic [15:0] MemAddr, InstructionOut, PCOut;

    fetch_stage #(.RESET_PC(RST_PC), .HLT_OPCODE(4'hF)) dut (
        .clk(clk), .rst(rst), .StallIn(StallIn), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .MemReady(MemReady), .MemData(MemData),
        .MemEnable(MemEnable), .MemAddr(MemAddr), .InstructionOut(InstructionOut),
        .PCOut(PCOut), .HltOut(HltOut), .NoopOut(NoopOut),
        .IFIDWriteEnable(IFIDWriteEnable), .Halted(Halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [15:0] addr;
        logic        wr, noop, hlt, halted;
        logic [15:0] instr, pcout;
    } outs_t;

    typedef struct {
        logic        rst, stall, br;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        outs_t       exp;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic outs_t o(input logic en, input logic [15:0] addr, input logic wr, noop,
                                hlt, halted, input logic [15:0] instr, pcout);
        return '{en, addr, wr, noop, hlt, halted, instr, pcout};
    endfunction

    task automatic v(input logic r, s, b, input logic [15:0] t, input logic rd,
                     input logic [15:0] d, input outs_t e);
        vec_t x;
        x.rst = r; x.stall = s; x.br = b; x.tgt = t; x.rdy = rd; x.data = d; x.exp = e;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic outs_t actual();
        return '{MemEnable, MemAddr, IFIDWriteEnable, NoopOut, HltOut, Halted, InstructionOut, PCOut};
    endfunction

    // Every real (non-flush) IF/ID write must match the oldest expected delivery.
    always @(negedge clk) begin
        if (!rst && IFIDWriteEnable && !NoopOut) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_write: got instr %h pc %h, none expected",
                         InstructionOut, PCOut);
            end else begin
                check("sb_write", {31'd0, InstructionOut, PCOut, HltOut}, {31'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        // rst stall br tgt rdy data | en addr wr noop hlt halted instr pcout
        v(1,0,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(1,0,0,16'h0000,1,16'h5555, o(0,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h1234, o(1,16'h0000,1,0,0,0,16'h1234,16'h0002));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0002,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h5678, o(1,16'h0002,1,0,0,0,16'h5678,16'h0004));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0004,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0004,0,0,0,0,16'h0000,16'h0000));
        v(0,1,0,16'h0000,1,16'hABCD, o(1,16'h0004,0,0,0,0,16'h0000,16'h0000));
        v(0,1,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'hABCD,16'h0000));
        v(0,1,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'hABCD,16'h0000));
        v(0,1,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'hABCD,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(0,16'h0000,1,0,0,0,16'hABCD,16'h0006));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0006,0,0,0,0,16'h0000,16'h0000));
        v(0,0,1,16'h0040,0,16'h0000, o(1,16'h0006,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'hDEAD, o(0,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0040,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h1111, o(1,16'h0040,1,0,0,0,16'h1111,16'h0042));
        v(0,0,1,16'h0008,0,16'h0000, o(0,16'h0000,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0008,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'hF000, o(1,16'h0008,1,0,1,0,16'hF000,16'h000A));
        v(0,0,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,1,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h1234, o(0,16'h0000,0,0,0,1,16'h0000,16'h0000));
        v(0,0,1,16'h0010,0,16'h0000, o(0,16'h0000,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0010,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h2222, o(1,16'h0010,1,0,0,0,16'h2222,16'h0012));
        v(0,0,1,16'hFFFE,0,16'h0000, o(0,16'h0000,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'hFFFE,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h3333, o(1,16'hFFFE,1,0,0,0,16'h3333,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h4444, o(1,16'h0000,1,0,0,0,16'h4444,16'h0002));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0002,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0002,0,0,0,0,16'h0000,16'h0000));
        v(1,0,0,16'h0000,0,16'h0000, o(0,16'h0000,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'hBEEF, o(1,RST_PC  ,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,RST_PC  ,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h5555, o(1,RST_PC  ,1,0,0,0,16'h5555,16'h0002));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0002,0,0,0,0,16'h0000,16'h0000));
        v(0,1,0,16'h0000,1,16'h6666, o(1,16'h0002,0,0,0,0,16'h0000,16'h0000));
        v(0,1,1,16'h0020,0,16'h0000, o(0,16'h0000,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0020,0,0,0,0,16'h0000,16'h0000));
        v(0,0,1,16'h0030,1,16'h7777, o(1,16'h0020,1,1,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,0,16'h0000, o(1,16'h0030,0,0,0,0,16'h0000,16'h0000));
        v(0,0,0,16'h0000,1,16'h8888, o(1,16'h0030,1,0,0,0,16'h8888,16'h0032));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst = vecs[i].rst; StallIn = vecs[i].stall; BranchTaken = vecs[i].br;
            BranchTarget = vecs[i].tgt; MemReady = vecs[i].rdy; MemData = vecs[i].data;
            if (vecs[i].exp.wr && !vecs[i].exp.noop)
                sb.push_back({vecs[i].exp.instr, vecs[i].exp.pcout, vecs[i].exp.hlt});
            @(negedge clk);
            check($sformatf("vec%0d", i), {11'd0, actual()}, {11'd0, vecs[i].exp});
        end

        // Long memory latency: address must stay put until the response arrives.
        @(posedge clk); #1;
        StallIn = 0; BranchTaken = 0; MemReady = 0; MemData = '0;
        @(negedge clk);
        check("lat_req", {47'd0, MemEnable, MemAddr}, {47'd0, 1'b1, 16'h0032});
        lat = $urandom_range(3, 8);
        for (int k = 0; k < lat; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("lat_hold", {46'd0, MemEnable, MemAddr, IFIDWriteEnable},
                  {46'd0, 1'b1, 16'h0032, 1'b0});
        end
        @(posedge clk); #1;
        MemReady = 1; MemData = 16'h9ABC;
        sb.push_back({16'h9ABC, 16'h0034, 1'b0});
        @(negedge clk);
        check("lat_wr", {63'd0, IFIDWriteEnable}, {63'd0, 1'b1});

        // Reset asserted between edges must clear outputs immediately.
        @(posedge clk); #1;
        MemReady = 0;
        #2;
        rst = 1;
        #1;
        check("arst_async", {47'd0, MemEnable, MemAddr}, 64'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("arst_first_req", {47'd0, MemEnable, MemAddr}, {47'd0, 1'b1, RST_PC});

        @(posedge clk); #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter HLT_OPCODE, default 4'hF: opcode in Instruction[15:12] that halts fetch.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 StallIn  in  1  hazard-unit stall; hold PC and block IF/ID write.
REQ-006 BranchTaken  in  1  redirect from ID stage.
REQ-007 BranchTarget  in  16  redirect address, valid when BranchTaken=1.
REQ-008 MemReady  in  1  instruction memory returns MemData this cycle.
REQ-009 MemData  in  16  instruction word from memory.
REQ-010 MemEnable  out  1  memory request active.
REQ-011 MemAddr  out  16  fetch address.
REQ-012 InstructionOut  out  16  instruction to IF/ID register.
REQ-013 PCOut  out  16  fetch PC + 2 to IF/ID register.
REQ-014 HltOut  out  1  delivered instruction is a halt.
REQ-015 NoopOut  out  1  flush IF/ID this cycle.
REQ-016 IFIDWriteEnable  out  1  IF/ID register write enable.
REQ-017 Halted  out  1  fetch permanently stopped on halt.

Function
REQ-018 States SHALL be FETCH, WAIT, HOLD and HALTED.
REQ-019 FETCH: MemEnable=1, MemAddr=PC; next state WAIT.
REQ-020 WAIT: MemEnable=1 with MemAddr=PC held stable until MemReady=1; memory latency is unbounded; minimum throughput is 2 cycles per instruction.
REQ-021 WAIT with MemReady=1, discard flag clear and StallIn=0: IFIDWriteEnable=1; InstructionOut=MemData; PCOut=PC+2 (16-bit wrap, FFFE+2=0000); PC<=PC+2; next state FETCH.
REQ-022 WAIT with MemReady=1, discard flag clear and StallIn=1: MemData captured into the hold buffer; IFIDWriteEnable=0; next state HOLD.
REQ-023 HOLD: InstructionOut is driven from the hold buffer; MemEnable=0; when StallIn falls, delivery proceeds as in REQ-021.
REQ-024 Delivery of an instruction with [15:12]=HLT_OPCODE: HltOut=1 and IFIDWriteEnable=1; PC not incremented; next state HALTED.
REQ-025 HALTED: MemEnable=0; IFIDWriteEnable=0; Halted=1; the state is left only by BranchTaken or rst.
REQ-026 BranchTaken=1 has priority over StallIn, MemReady and halt detection, in every state: PC<=BranchTarget; NoopOut=1; IFIDWriteEnable=1; HltOut=0.
REQ-027 Branch in WAIT with MemReady=0: the discard flag is set, and the outstanding response is dropped when it arrives; then next state FETCH at the new PC.
REQ-028 Branch in WAIT with MemReady=1 in the same cycle: MemData is dropped; next state FETCH.
REQ-029 Branch in HOLD: the buffer is invalidated; next state FETCH.
REQ-030 Branch in HALTED (a speculative halt): next state FETCH; Halted=0.
REQ-031 Branch in FETCH: the request is suppressed (MemEnable=0); next state FETCH.
REQ-032 NoopOut=0 and HltOut=0 whenever IFIDWriteEnable=0.

Reset
REQ-033 While rst=1, all outputs SHALL be 0, PC=RESET_PC, state=FETCH, and the discard flag and hold buffer are cleared.
REQ-034 Reset asserted mid-WAIT SHALL abandon the request; a late MemReady is ignored until the first FETCH after deassertion.
REQ-035 The first request (MemAddr=RESET_PC) SHALL issue in the first cycle after rst deasserts.

Structure
REQ-036 Shared package fetch_pkg SHALL hold the state encoding, the HLT opcode field position and PC_INCR=16'd2.
REQ-037 The PC register with enable SHALL be the sub-module fetch_pc_reg; the rest is flat.

Verification
REQ-038 Reset, then MemReady on the cycle after each request, with data 16'h1234 and 16'h5678 -> MemAddr 0000 then 0002; two IF/ID writes; PCOut 0002 then 0004.
REQ-039 StallIn=1 during MemReady with data 16'hABCD, held 3 cycles -> HOLD, IFIDWriteEnable=0 for 3 cycles, then one write of ABCD; MemEnable=0 throughout HOLD.
REQ-040 BranchTaken with target 16'h0040 in WAIT, MemReady arriving 2 cycles later with 16'hDEAD -> NoopOut=1 pulse; DEAD never written; next MemAddr=0040.
REQ-041 Fetch of 16'hF000 at PC 0008 -> HltOut=1 write; Halted=1; no further MemEnable; a later BranchTaken with target 0010 -> fetch resumes at 0010.
REQ-042 Assert rst mid-WAIT, then apply MemReady in the first post-reset cycle -> the data is ignored, and MemAddr=RESET_PC is requested afresh.
REQ-043 PC 16'hFFFE delivered -> PCOut=0000 and next MemAddr=0000.
